// File: rtl/mbi5153_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mbi5153_pkg
// Purpose  : Shared command encodings, latch lengths and FSM state type for
//            the MBI5153 line transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package mbi5153_pkg;

    localparam logic [1:0] c_cmd_data  = 2'd0;
    localparam logic [1:0] c_cmd_vsync = 2'd1;
    localparam logic [1:0] c_cmd_cfg   = 2'd2;
    localparam logic [1:0] c_cmd_rsvd  = 2'd3;

    // LE widths in DCLKs: data latch, VSYNC, config write
    localparam int c_latch_len_data  = 1;
    localparam int c_latch_len_vsync = 3;
    localparam int c_latch_len_cfg   = 4;

    localparam int c_word_bits = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Left-justify a colour value inside a 16-bit channel word, zero padded.
    function automatic logic [15:0] chan_word(input logic [15:0] v, input int bits);
        return v << (c_word_bits - bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mbi5153_lane_shift.sv
`default_nettype none
// ============================================================================
// Module   : mbi5153_lane_shift
// Purpose  : 3x16-bit R/G/B load/shift register for one lane; the loaded
//            word's MSB is bypassed to the output on the load cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mbi5153_lane_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_shift,
    input  logic [47:0] i_word,
    output logic        o_r,
    output logic        o_g,
    output logic        o_b
);

    logic [47:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= {i_word[46:32], 1'b0, i_word[30:16], 1'b0, i_word[14:0], 1'b0};
        end else if (i_shift) begin
            r_sr <= {r_sr[46:32], 1'b0, r_sr[30:16], 1'b0, r_sr[14:0], 1'b0};
        end
    end

    assign o_r = i_load ? i_word[47] : r_sr[47];
    assign o_g = i_load ? i_word[31] : r_sr[31];
    assign o_b = i_load ? i_word[15] : r_sr[15];

endmodule
`default_nettype wire

// File: rtl/mbi5153_line_tx.sv
`default_nettype none
// ============================================================================
// Module   : mbi5153_line_tx
// Purpose  : Serialises display lines, VSYNC and config writes onto an
//            MBI5153 driver chain with gated DCLK and LE generation.
// Revision : 1.0 - initial release
// ============================================================================
module mbi5153_line_tx
    import mbi5153_pkg::*;
#(
    parameter int NUM_IC_CHAIN = 4,
    parameter int NUM_CH_IC    = 16,
    parameter int NUM_LANES    = 3,
    parameter int COLOR_BITS   = 8,
    parameter int RAM_LAT      = 1,
    parameter int ADDR_WIDTH   = $clog2(NUM_IC_CHAIN*NUM_CH_IC)
) (
    input  logic                              CLK,
    input  logic                              RESET_N,
    input  logic                              REQUEST,
    input  logic [1:0]                        CMD,
    input  logic [15:0]                       CFG_WORD,
    input  logic [NUM_LANES*3*COLOR_BITS-1:0] DATA,
    output logic                              READY,
    output logic                              ACTIVE,
    output logic                              DCLK_ENA,
    output logic                              LATCH,
    output logic [NUM_LANES-1:0]              R,
    output logic [NUM_LANES-1:0]              G,
    output logic [NUM_LANES-1:0]              B,
    output logic [ADDR_WIDTH-1:0]             ADDR,
    output logic                              TX_DONE
);

    localparam int c_word_w  = (NUM_IC_CHAIN > 1) ? $clog2(NUM_IC_CHAIN) : 1;
    localparam int c_pass_w  = (NUM_CH_IC > 1) ? $clog2(NUM_CH_IC) : 1;
    localparam int c_fetch_w = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_cmd;
    logic [15:0]           r_cfg;
    logic [3:0]            r_bit_cnt;
    logic [c_word_w-1:0]   r_word_cnt;
    logic [c_pass_w-1:0]   r_pass_cnt;
    logic [c_fetch_w-1:0]  r_fetch_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic w_accept;
    logic w_last_word;
    logic w_last_pass;
    logic w_last_fetch;
    logic w_last_dclk;
    logic w_load;
    logic [NUM_LANES-1:0] w_r, w_g, w_b;

    assign w_accept     = REQUEST && READY && (CMD != c_cmd_rsvd);
    assign w_last_word  = (r_word_cnt == c_word_w'(NUM_IC_CHAIN - 1));
    assign w_last_pass  = (r_pass_cnt == c_pass_w'(NUM_CH_IC - 1));
    assign w_last_fetch = (r_fetch_cnt == c_fetch_w'(RAM_LAT - 1));
    assign w_last_dclk  = (r_cmd == c_cmd_vsync) ? (r_bit_cnt == 4'(c_latch_len_vsync - 1))
                                                 : ((r_bit_cnt == 4'd15) && w_last_word);
    assign w_load       = (r_state == ST_SHIFT) && (r_bit_cnt == 4'd0);

    always_comb begin
        w_next   = r_state;
        READY    = 1'b0;
        ACTIVE   = 1'b0;
        DCLK_ENA = 1'b0;
        LATCH    = 1'b0;
        TX_DONE  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                READY   = 1'b1;
                TX_DONE = (r_state == ST_DONE);
                if (w_accept) begin
                    w_next = (CMD == c_cmd_data) ? ST_FETCH : ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                ACTIVE = 1'b1;
                if (w_last_fetch) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ACTIVE   = 1'b1;
                DCLK_ENA = 1'b1;
                case (r_cmd)
                    c_cmd_vsync: LATCH = 1'b1;
                    c_cmd_cfg:   LATCH = w_last_word && (r_bit_cnt >= 4'(16 - c_latch_len_cfg));
                    default:     LATCH = w_last_word && (r_bit_cnt >= 4'(16 - c_latch_len_data));
                endcase
                if (w_last_dclk) begin
                    w_next = ((r_cmd == c_cmd_data) && !w_last_pass) ? ST_GAP : ST_DONE;
                end
            end
            ST_GAP: begin
                ACTIVE = 1'b1;
                w_next = ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_cmd       <= c_cmd_data;
            r_cfg       <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_pass_cnt  <= '0;
            r_fetch_cnt <= '0;
            r_addr      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cmd       <= CMD;
                r_cfg       <= CFG_WORD;
                r_bit_cnt   <= '0;
                r_word_cnt  <= '0;
                r_pass_cnt  <= '0;
                r_fetch_cnt <= '0;
                r_addr      <= '0;
            end else begin
                case (r_state)
                    ST_FETCH: r_fetch_cnt <= r_fetch_cnt + 1'b1;
                    ST_SHIFT: begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) begin
                            r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
                        end
                        // Next IC's word is addressed RAM_LAT cycles before its load slot
                        if ((r_cmd == c_cmd_data) && (r_bit_cnt == 4'(15 - RAM_LAT)) && !w_last_word) begin
                            r_addr <= r_addr + ADDR_WIDTH'(NUM_CH_IC);
                        end
                        if ((r_cmd == c_cmd_data) && w_last_dclk && !w_last_pass) begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        r_fetch_cnt <= '0;
                        r_addr      <= ADDR_WIDTH'(r_pass_cnt);
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lanes
        logic [47:0] w_word;

        always_comb begin
            w_word = '0;
            case (r_cmd)
                c_cmd_data: w_word = {
                    chan_word(16'(DATA[k*3*COLOR_BITS + 2*COLOR_BITS +: COLOR_BITS]), COLOR_BITS),
                    chan_word(16'(DATA[k*3*COLOR_BITS +   COLOR_BITS +: COLOR_BITS]), COLOR_BITS),
                    chan_word(16'(DATA[k*3*COLOR_BITS              +: COLOR_BITS]), COLOR_BITS)};
                c_cmd_cfg:  w_word = {3{r_cfg}};
                default:    w_word = '0;
            endcase
        end

        mbi5153_lane_shift u_lane (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .i_load  (w_load),
            .i_shift (DCLK_ENA),
            .i_word  (w_word),
            .o_r     (w_r[k]),
            .o_g     (w_g[k]),
            .o_b     (w_b[k])
        );
    end

    assign R    = w_r & {NUM_LANES{DCLK_ENA}};
    assign G    = w_g & {NUM_LANES{DCLK_ENA}};
    assign B    = w_b & {NUM_LANES{DCLK_ENA}};
    assign ADDR = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_mbi5153_line_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbi5153_line_tx
// Purpose  : Directed, table-driven self-checking bench for mbi5153_line_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbi5153_line_tx;

    localparam int ICS   = 2;
    localparam int CHS   = 16;
    localparam int LANES = 2;
    localparam int CB    = 8;
    localparam int RL    = 1;
    localparam int AW    = $clog2(ICS*CHS);

    logic                  CLK = 1'b0;
    logic                  RESET_N = 1'b0;
    logic                  REQUEST = 1'b0;
    logic [1:0]            CMD = 2'd0;
    logic [15:0]           CFG_WORD = 16'h0;
    logic [LANES*3*CB-1:0] DATA;
    logic                  READY, ACTIVE, DCLK_ENA, LATCH, TX_DONE;
    logic [LANES-1:0]      R, G, B;
    logic [AW-1:0]         ADDR;

    int n_vec = 0;
    int n_err = 0;

    mbi5153_line_tx #(
        .NUM_IC_CHAIN(ICS), .NUM_CH_IC(CHS), .NUM_LANES(LANES),
        .COLOR_BITS(CB), .RAM_LAT(RL), .ADDR_WIDTH(AW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQUEST(REQUEST), .CMD(CMD),
        .CFG_WORD(CFG_WORD), .DATA(DATA), .READY(READY), .ACTIVE(ACTIVE),
        .DCLK_ENA(DCLK_ENA), .LATCH(LATCH), .R(R), .G(G), .B(B),
        .ADDR(ADDR), .TX_DONE(TX_DONE)
    );

    always #5 CLK = ~CLK;

    // RAM model: word(a) = {a, ~a, a ^ 8'h5A} on every lane, RL-cycle latency
    function automatic logic [23:0] ram_word(input logic [AW-1:0] a);
        logic [7:0] v;
        v = 8'(a);
        return {v, ~v, v ^ 8'h5A};
    endfunction

    logic [23:0] ram_pipe [RL];
    always @(posedge CLK) begin
        ram_pipe[0] <= ram_word(ADDR);
        for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign DATA = {LANES{ram_pipe[RL-1]}};

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] cfg;
        int          exp_dclks;
        int          exp_latch;
        int          exp_first;
        int          exp_done;
    } vec_t;

    // n-th DCLK of a transaction, colour 0=R 1=G 2=B
    function automatic logic exp_bit(input logic [1:0] cmd, input logic [15:0] cfg,
                                     input int n, input int color);
        logic [7:0]  a, c;
        logic [15:0] wd;
        if (cmd == 2'd2) return cfg[15 - (n % 16)];
        if (cmd == 2'd1) return 1'b0;
        a  = 8'((n / 32) + ((n % 32) / 16) * 16);
        c  = (color == 0) ? a : (color == 1) ? ~a : (a ^ 8'h5A);
        wd = {c, 8'h00};
        return wd[15 - (n % 16)];
    endfunction

    function automatic logic exp_latch(input logic [1:0] cmd, input int n);
        if (cmd == 2'd1) return 1'b1;
        if (cmd == 2'd2) return (n >= 28);
        return ((n % 32) == 31);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one command, monitor it cycle by cycle until TX_DONE (k = cycles after accept)
    task automatic run(input string id, input vec_t v, input bit noise);
        int k, n, first, done_k, lat, serr, lerr, aerr, actv_err, idle_err, rdy_done;
        logic [AW-1:0] prev_addr;
        k = 1; n = 0; first = -1; done_k = -1; lat = 0; serr = 0; lerr = 0;
        aerr = 0; actv_err = 0; idle_err = 0; rdy_done = 0; prev_addr = '0;
        check({id, "_ready_at_req"}, int'(READY), 1);
        CMD = v.cmd; CFG_WORD = v.cfg; REQUEST = 1'b1;
        tick();
        REQUEST = 1'b0;
        CFG_WORD = 16'hFFFF;
        while (done_k < 0 && k < 2000) begin
            if (DCLK_ENA) begin
                if (first < 0) first = k;
                for (int l = 0; l < LANES; l++) begin
                    if (R[l] !== exp_bit(v.cmd, v.cfg, n, 0)) serr++;
                    if (G[l] !== exp_bit(v.cmd, v.cfg, n, 1)) serr++;
                    if (B[l] !== exp_bit(v.cmd, v.cfg, n, 2)) serr++;
                end
                if (LATCH !== exp_latch(v.cmd, n)) lerr++;
                if (LATCH) lat++;
                if (v.cmd == 2'd0 && (n % 16) == 0 &&
                    int'(prev_addr) != (n / 32) + ((n % 32) / 16) * CHS) aerr++;
                n++;
            end else if (R != 0 || G != 0 || B != 0 || LATCH) begin
                idle_err++;
            end
            if (TX_DONE) begin
                done_k = k;
                rdy_done = int'(READY) + 2 * int'(ACTIVE);
            end else if (ACTIVE !== 1'b1 || READY !== 1'b0) begin
                actv_err++;
            end
            prev_addr = ADDR;
            if (done_k < 0) begin
                REQUEST = noise && ((k >= 100 && k < 103) || (k >= 400 && k < 402));
                CMD     = (k >= 400) ? 2'd2 : 2'd1;
                tick();
                k++;
            end
        end
        REQUEST = 1'b0;
        check({id, "_dclks"},      n,        v.exp_dclks);
        check({id, "_latches"},    lat,      v.exp_latch);
        check({id, "_first_dclk"}, first,    v.exp_first);
        check({id, "_done_cycle"}, done_k,   v.exp_done);
        check({id, "_bit_errs"},   serr,     0);
        check({id, "_latch_errs"}, lerr,     0);
        check({id, "_idle_errs"},  idle_err, 0);
        check({id, "_active_errs"}, actv_err, 0);
        check({id, "_ready_done"}, rdy_done, 1);
        if (v.cmd == 2'd0) check({id, "_addr_errs"}, aerr, 0);
    endtask

    function automatic int out_vec();
        return int'({READY, ACTIVE, DCLK_ENA, LATCH, R, G, B, ADDR, TX_DONE});
    endfunction

    localparam int RST_VEC = 32768;   // READY=1, everything else 0

    vec_t vecs[4];

    initial begin
        int cnt, dones, bad;
        // data line: first DCLK at RL+1, then 16 passes of 32 DCLKs separated by GAP+FETCH
        vecs[0] = '{cmd: 2'd1, cfg: 16'h0000, exp_dclks: 3,   exp_latch: 3,  exp_first: 1,    exp_done: 4};
        vecs[1] = '{cmd: 2'd2, cfg: 16'hA5C3, exp_dclks: 32,  exp_latch: 4,  exp_first: 1,    exp_done: 33};
        vecs[2] = '{cmd: 2'd0, cfg: 16'h0000, exp_dclks: 512, exp_latch: 16, exp_first: RL+1,
                    exp_done: RL + 1 + 512 + 15 * (1 + RL)};
        vecs[3] = '{cmd: 2'd2, cfg: 16'h0001, exp_dclks: 32,  exp_latch: 4,  exp_first: 1,    exp_done: 33};

        repeat (3) tick();
        check("reset_state", out_vec(), RST_VEC);
        RESET_N = 1'b1;
        tick();

        // Table runs back to back: each request is raised on the previous TX_DONE cycle
        for (int i = 0; i < 4; i++) run($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Reserved command while idle is ignored
        repeat (2) tick();
        bad = 0;
        CMD = 2'd3; REQUEST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (READY !== 1'b1 || ACTIVE !== 1'b0 || DCLK_ENA !== 1'b0) bad++;
        end
        REQUEST = 1'b0;
        check("cmd3_ignored", bad, 0);

        // Data line with stray requests mid-line must complete unaltered
        run("noisy_line", vecs[2], 1'b1);

        // Asynchronous reset at DCLK 200 of a line
        tick();
        CMD = 2'd0; REQUEST = 1'b1;
        tick();
        REQUEST = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400 && cnt < 200; i++) begin
            if (DCLK_ENA) cnt++;
            if (cnt < 200) tick();
        end
        check("dclk200_reached", cnt, 200);
        RESET_N = 1'b0;
        #1;
        check("reset_mid_line", out_vec(), RST_VEC);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (TX_DONE || out_vec() != RST_VEC) dones++;
        end
        check("reset_held_quiet", dones, 0);
        RESET_N = 1'b1;
        run("vsync_after_reset", vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mbi5153_line_tx.md
MBI5153_LINE_TX -- requirements
Module: mbi5153_line_tx

Interface
REQ-001 SHALL have parameter NUM_IC_CHAIN, default 4: number of driver ICs per chain, 1..16.
REQ-002 SHALL have parameter NUM_CH_IC, default 16: channels per IC, 1..16.
REQ-003 SHALL have parameter NUM_LANES, default 3: parallel RGB lanes, 1..8.
REQ-004 SHALL have parameter COLOR_BITS, default 8: colour depth per component, 1..16.
REQ-005 SHALL have parameter RAM_LAT, default 1: RAM read latency in CLKs, 1..3.
REQ-006 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_IC_CHAIN*NUM_CH_IC): RAM address width.
REQ-007 SHALL have these ports, in this order:
- CLK  in  1  clock; one clock, all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQUEST  in  1  command request; sampled only while READY=1.
- CMD  in  2  command: 0 = data line, 1 = VSYNC, 2 = config write, 3 = reserved.
- CFG_WORD  in  16  config register value for CMD=2.
- DATA  in  NUM_LANES*3*COLOR_BITS  RGB word per lane; lane k occupies bits [k*3*COLOR_BITS +: 3*COLOR_BITS], ordered R,G,B from MSB.
- READY  out  1  block is idle and will accept a request.
- ACTIVE  out  1  a command is executing.
- DCLK_ENA  out  1  DCLK gate; each CLK cycle with DCLK_ENA=1 is one DCLK.
- LATCH  out  1  MBI5153 LE.
- R, G, B  out  NUM_LANES each  serial data.
- ADDR  out  ADDR_WIDTH  RAM read address.
- TX_DONE  out  1  one-cycle completion strobe.

Function
REQ-008 SHALL accept a request only when REQUEST=1, READY=1 and CMD!=3; READY SHALL fall on the next cycle; a request with CMD=3 SHALL be ignored.
REQ-009 SHALL follow the state sequence IDLE -> FETCH (RAM_LAT cycles) -> SHIFT -> GAP (1 cycle) -> FETCH ... -> DONE -> IDLE for data lines, and IDLE -> SHIFT -> DONE -> IDLE for CMD 1 and 2.
REQ-010 A data line SHALL consist of NUM_CH_IC passes p = 0..NUM_CH_IC-1; pass p SHALL read ADDR = p + i*NUM_CH_IC for i = 0..NUM_IC_CHAIN-1, in that order.
REQ-011 Each channel word SHALL be 16 bits, MSB first: COLOR_BITS data bits followed by (16-COLOR_BITS) zero bits.
REQ-012 Each pass SHALL be NUM_IC_CHAIN*16 contiguous DCLKs. ADDR for the next word SHALL be issued so that DATA is valid exactly RAM_LAT cycles later, with no DCLK gaps inside a pass.
REQ-013 For a data line, LATCH SHALL be 1 during the last DCLK of every pass.
REQ-014 CMD=1 (VSYNC) SHALL produce 3 DCLKs, with LATCH=1 on all 3 and R=G=B=0.
REQ-015 CMD=2 SHALL shift CFG_WORD, captured at accept, once per IC (NUM_IC_CHAIN*16 DCLKs) on every lane and colour. LATCH SHALL be 1 during the last 4 DCLKs.
REQ-016 R/G/B SHALL change on the same cycle DCLK_ENA is asserted for the corresponding bit. Outside DCLK_ENA, R/G/B SHALL be 0.
REQ-017 The first DCLK SHALL occur RAM_LAT+1 cycles after accept for CMD=0, and 1 cycle after accept for CMD 1 and 2.
REQ-018 TX_DONE SHALL pulse for one cycle, the cycle after the final DCLK. READY SHALL rise on the same cycle.
REQ-019 ACTIVE SHALL be 1 from the cycle after accept through the final DCLK.
REQ-020 REQUEST while READY=0 SHALL be ignored and not queued.
REQ-021 Internal counters SHALL be sized by $clog2 of their maximum count. The pass counter SHALL terminate on its last value without wrapping.

Reset
REQ-022 RESET_N=0 SHALL immediately force: state IDLE, READY=1, ACTIVE=0, DCLK_ENA=0, LATCH=0, R=G=B=0, ADDR=0, TX_DONE=0, all shift registers 0.
REQ-023 Reset during an operation SHALL abort it without a TX_DONE pulse. The first cycle after release SHALL accept a new request.

Structure
REQ-024 The CMD encodings and the latch lengths (1, 3, 4) SHALL be constants in shared package mbi5153_pkg.
REQ-025 The per-lane 3x16-bit load/shift register SHALL be sub-module mbi5153_lane_shift, instantiated NUM_LANES times through a generate loop.

Verification
REQ-026 The bench SHALL use NUM_IC_CHAIN=2, NUM_CH_IC=16, NUM_LANES=2, COLOR_BITS=8, RAM_LAT=1, with a RAM model where word(a) = {a, ~a, a^8'h5A}. Scenarios:
- CMD=0 request -> 512 DCLKs; 16 LATCH pulses; ADDR order 0,16,1,17,...,15,31; lane0 first word bits 0x0000 (R of address 0); TX_DONE at cycle 2+512+15 gaps+1.
- CMD=1 -> exactly 3 DCLKs, all with LATCH=1; TX_DONE 1 cycle after the third.
- CMD=2 with CFG_WORD=16'hA5C3 -> 32 DCLKs carrying A5C3 twice on all 6 outputs; LATCH=1 on DCLKs 29..32.
- REQUEST with CMD=3, and REQUEST pulses mid-line -> no effect; READY unchanged and the line completes unaltered.
- RESET_N low at DCLK 200 of a line -> all outputs at reset values immediately, no TX_DONE; a new CMD=1 accepted on the first cycle after release.
- Back-to-back: new REQUEST on the TX_DONE cycle -> accepted; first DCLK 2 cycles later.
